// File: rtl/if_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_unit_pkg
//  Description : Shared widths, reset constants and fetch FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_fetch_unit_pkg;

    localparam int XLEN        = 32;
    localparam int INST_ADDR_W = XLEN;
    localparam int INST_W      = 32;

    localparam logic [INST_ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [INST_W-1:0]      DEFAULT_NOP_INST = 32'h0000_0013;
    localparam logic [INST_ADDR_W-1:0] INST_BYTES       = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } fetch_state_e;

    function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] addr);
        return {addr[INST_ADDR_W-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch_unit_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_unit_fifo
//  Description : Synchronous pc/inst FIFO with push, pop, flush and count.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit_fifo
    import if_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [INST_ADDR_W-1:0] push_pc,
    input  logic [INST_W-1:0]      push_inst,
    input  logic                   pop,
    input  logic                   flush,
    output logic [CNT_W-1:0]       count,
    output logic                   empty,
    output logic [INST_ADDR_W-1:0] head_pc,
    output logic [INST_W-1:0]      head_inst
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [INST_ADDR_W-1:0] r_pc_mem   [DEPTH];
    logic [INST_W-1:0]      r_inst_mem [DEPTH];
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [CNT_W-1:0]       r_count;

    logic w_do_pop;
    logic w_do_push;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_pop  = pop && (r_count != '0);
    assign w_do_push = push && !flush && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_pc_mem[r_wr_ptr]   <= push_pc;
            r_inst_mem[r_wr_ptr] <= push_inst;
        end
    end

    assign count     = r_count;
    assign empty     = (r_count == '0);
    assign head_pc   = r_pc_mem[r_rd_ptr];
    assign head_inst = r_inst_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_unit
//  Description : Instruction fetch stage: PC, single-outstanding memory
//                requests, fetched-word buffer and redirect handling.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int                     FIFO_DEPTH = 2,
    parameter logic [INST_W-1:0]      NOP_INST   = DEFAULT_NOP_INST
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   branch_flag_i,
    input  logic [INST_ADDR_W-1:0] branch_addr_i,
    output logic                   mem_req_o,
    output logic [INST_ADDR_W-1:0] mem_addr_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [INST_W-1:0]      mem_rdata_i,
    output logic [INST_ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0]      inst_o,
    output logic                   inst_valid_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e           r_state;
    fetch_state_e           w_state_next;
    logic [INST_ADDR_W-1:0] r_fetch_pc;
    logic [INST_ADDR_W-1:0] w_fetch_pc_next;
    logic                   r_drop;
    logic                   w_drop_next;

    logic                   w_push;
    logic                   w_pop;
    logic [CNT_W-1:0]       w_count;
    logic                   w_empty;
    logic [INST_ADDR_W-1:0] w_head_pc;
    logic [INST_W-1:0]      w_head_inst;
    logic                   w_has_space;
    logic [CNT_W:0]         w_count_after_push;
    logic                   w_space_after_push;
    logic [INST_ADDR_W-1:0] w_target;

    assign w_target    = word_align(branch_addr_i);
    assign w_has_space = (w_count < CNT_W'(FIFO_DEPTH));

    // Occupancy if the returning word is pushed, counting a same-cycle pop.
    assign w_count_after_push = {1'b0, w_count} + (CNT_W+1)'(1) - (CNT_W+1)'(w_pop);
    assign w_space_after_push = (w_count_after_push < (CNT_W+1)'(FIFO_DEPTH));

    // A redirect flushes the buffer, so the head is never consumed in that cycle.
    assign w_pop = !w_empty && !stall_i && !branch_flag_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_drop     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_drop     <= w_drop_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_drop_next     = r_drop;
        w_push          = 1'b0;
        mem_req_o       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (branch_flag_i) begin
                    w_fetch_pc_next = w_target;
                    w_state_next    = S_REQ;
                end else if (w_has_space) begin
                    w_state_next = S_REQ;
                end
            end

            S_REQ: begin
                mem_req_o = 1'b1;
                if (branch_flag_i) begin
                    w_fetch_pc_next = w_target;
                end
                if (mem_gnt_i) begin
                    w_state_next = S_WAIT;
                    if (branch_flag_i) begin
                        w_drop_next = 1'b1;
                    end else begin
                        w_fetch_pc_next = r_fetch_pc + INST_BYTES;
                    end
                end
            end

            S_WAIT: begin
                if (branch_flag_i) begin
                    w_fetch_pc_next = w_target;
                    if (mem_rvalid_i) begin
                        w_drop_next  = 1'b0;
                        w_state_next = S_REQ;
                    end else begin
                        w_drop_next = 1'b1;
                    end
                end else if (mem_rvalid_i) begin
                    if (r_drop) begin
                        w_drop_next  = 1'b0;
                        w_state_next = S_REQ;
                    end else begin
                        w_push       = 1'b1;
                        w_state_next = w_space_after_push ? S_REQ : S_IDLE;
                    end
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // fetch_pc has already advanced past the outstanding word while waiting.
    if_fetch_unit_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_pc   (r_fetch_pc - INST_BYTES),
        .push_inst (mem_rdata_i),
        .pop       (w_pop),
        .flush     (branch_flag_i),
        .count     (w_count),
        .empty     (w_empty),
        .head_pc   (w_head_pc),
        .head_inst (w_head_inst)
    );

    assign mem_addr_o   = r_fetch_pc;
    assign inst_valid_o = !w_empty;
    assign pc_o         = w_empty ? '0 : w_head_pc;
    assign inst_o       = w_empty ? NOP_INST : w_head_inst;

endmodule
`default_nettype wire
